// File: rtl/frog_hop_ctrl.sv
// Frog hop sequencer: turns key levels into fixed-length hops and handles
// death/respawn, goal scoring, lives and game-over bookkeeping.
module frog_hop_ctrl #(
  parameter int HOP_TICKS      = 10,
  parameter int COOLDOWN_TICKS = 4,
  parameter int DEATH_TICKS    = 30,
  parameter int LIVES          = 3,
  parameter int SCORE_W        = 8
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic               timer_done,
  input  logic               restart,
  input  logic               key_up,
  input  logic               key_down,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               collision,
  input  logic               reached_goal,
  output logic               up,
  output logic               down,
  output logic               left,
  output logic               right,
  output logic               reset_position,
  output logic               hop_active,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  localparam int MAX_TICKS = (HOP_TICKS > COOLDOWN_TICKS) ?
                             ((HOP_TICKS > DEATH_TICKS) ? HOP_TICKS : DEATH_TICKS) :
                             ((COOLDOWN_TICKS > DEATH_TICKS) ? COOLDOWN_TICKS : DEATH_TICKS);
  localparam int CNT_W = $clog2(MAX_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HOP       = 3'd1,
    S_COOLDOWN  = 3'd2,
    S_DYING     = 3'd3,
    S_RESPAWN   = 3'd4,
    S_GAME_OVER = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  state_t             state_q, state_d;
  dir_t               dir_q, dir_d;
  logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [2:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               any_key_s;
  logic [SCORE_W-1:0] score_inc_s;

  assign any_key_s   = key_up | key_down | key_left | key_right;
  assign score_inc_s = (score_q == {SCORE_W{1'b1}}) ? score_q : (score_q + {{(SCORE_W-1){1'b0}}, 1'b1});

  // State, counter, direction and bookkeeping registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= S_IDLE;
      dir_q      <= DIR_UP;
      tick_cnt_q <= '0;
      lives_q    <= 3'(LIVES);
      score_q    <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      tick_cnt_q <= tick_cnt_d;
      lives_q    <= lives_d;
      score_q    <= score_d;
    end
  end

  // Next-state logic; lives drop on the way into a death respawn so RESPAWN
  // already shows the new count and can decide between IDLE and GAME_OVER.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    tick_cnt_d = tick_cnt_q;
    lives_d    = lives_q;
    score_d    = score_q;
    if (restart) begin
      state_d    = S_RESPAWN;
      tick_cnt_d = '0;
      lives_d    = 3'(LIVES);
      score_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (collision) begin
            state_d    = S_DYING;
            tick_cnt_d = '0;
          end else if (reached_goal) begin
            state_d = S_RESPAWN;
            score_d = score_inc_s;
          end else if (any_key_s) begin
            state_d    = S_HOP;
            tick_cnt_d = '0;
            if (key_up) begin
              dir_d = DIR_UP;
            end else if (key_down) begin
              dir_d = DIR_DOWN;
            end else if (key_left) begin
              dir_d = DIR_LEFT;
            end else begin
              dir_d = DIR_RIGHT;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_HOP: begin
          if (collision) begin
            state_d    = S_DYING;
            tick_cnt_d = '0;
          end else if (timer_done) begin
            if (tick_cnt_q == CNT_W'(HOP_TICKS - 1)) begin
              state_d    = S_COOLDOWN;
              tick_cnt_d = '0;
            end else begin
              tick_cnt_d = tick_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_d = S_HOP;
          end
        end
        S_COOLDOWN: begin
          if (collision) begin
            state_d    = S_DYING;
            tick_cnt_d = '0;
          end else if (reached_goal) begin
            state_d    = S_RESPAWN;
            tick_cnt_d = '0;
            score_d    = score_inc_s;
          end else if (timer_done) begin
            if (tick_cnt_q == CNT_W'(COOLDOWN_TICKS - 1)) begin
              state_d    = S_IDLE;
              tick_cnt_d = '0;
            end else begin
              tick_cnt_d = tick_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_d = S_COOLDOWN;
          end
        end
        S_DYING: begin
          if (timer_done) begin
            if (tick_cnt_q == CNT_W'(DEATH_TICKS - 1)) begin
              state_d    = S_RESPAWN;
              tick_cnt_d = '0;
              lives_d    = (lives_q == 3'd0) ? 3'd0 : (lives_q - 3'd1);
            end else begin
              tick_cnt_d = tick_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_d = S_DYING;
          end
        end
        S_RESPAWN: begin
          if (lives_q == 3'd0) begin
            state_d = S_GAME_OVER;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_GAME_OVER: begin
          state_d = S_GAME_OVER;
        end
        default: begin
          state_d    = S_IDLE;
          tick_cnt_d = '0;
        end
      endcase
    end
  end

  // Direction outputs are combinational so the motion block steps on the
  // same timer_done that advances tick_cnt.
  always_comb begin
    up    = 1'b0;
    down  = 1'b0;
    left  = 1'b0;
    right = 1'b0;
    if (state_q == S_HOP) begin
      case (dir_q)
        DIR_UP:    up    = 1'b1;
        DIR_DOWN:  down  = 1'b1;
        DIR_LEFT:  left  = 1'b1;
        DIR_RIGHT: right = 1'b1;
        default:   up    = 1'b0;
      endcase
    end else begin
      up = 1'b0;
    end
  end

  assign reset_position = (state_q == S_RESPAWN);
  assign hop_active     = (state_q == S_HOP);
  assign game_over      = (state_q == S_GAME_OVER);
  assign lives          = lives_q;
  assign score          = score_q;

endmodule

// File: tb/tb_frog_hop_ctrl.sv
// Directed self-checking bench for frog_hop_ctrl.
module tb_frog_hop_ctrl;

  logic       CLK = 1'b0;
  logic       RESETn;
  logic       timer_done, restart;
  logic       key_up, key_down, key_left, key_right;
  logic       collision, reached_goal;
  logic       up, down, left, right, reset_position, hop_active, game_over;
  logic [2:0] lives;
  logic [7:0] score;

  int errors = 0;
  int checks = 0;
  logic left_seen;

  frog_hop_ctrl dut (
    .CLK(CLK), .RESETn(RESETn), .timer_done(timer_done), .restart(restart),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .collision(collision), .reached_goal(reached_goal),
    .up(up), .down(down), .left(left), .right(right),
    .reset_position(reset_position), .hop_active(hop_active),
    .lives(lives), .score(score), .game_over(game_over)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (left === 1'b1) left_seen = 1'b1;

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      timer_done = 1'b1;
      cycle();
      timer_done = 1'b0;
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if ({up, down, left, right} !== 4'b0000) begin errors++; $display("FAIL reset_dirs: got %b want 0000", {up, down, left, right}); end
    checks++; if (reset_position !== 1'b0) begin errors++; $display("FAIL reset_rp: got %b want 0", reset_position); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_go: got %b want 0", game_over); end
    checks++; if (hop_active !== 1'b0) begin errors++; $display("FAIL reset_hop: got %b want 0", hop_active); end
    checks++; if (lives !== 3'd3) begin errors++; $display("FAIL reset_lives: got %0d want 3", lives); end
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", score); end
    RESETn = 1'b1;
    cycle();
  endtask

  task automatic test_single_hop();
    int n;
    n = 0;
    key_up = 1'b1;
    cycle();
    key_up = 1'b0;
    checks++; if ({up, hop_active} !== 2'b11) begin errors++; $display("FAIL hop_start: got up=%b hop=%b want 1 1", up, hop_active); end
    for (int k = 0; k < 20; k++) begin
      if (hop_active !== 1'b1) break;
      repeat (7) cycle();
      timer_done = 1'b1;
      if (up === 1'b1) n++;
      cycle();
      timer_done = 1'b0;
    end
    checks++; if (n !== 10) begin errors++; $display("FAIL hop_len: got %0d ticks want 10", n); end
    checks++; if ({up, hop_active} !== 2'b00) begin errors++; $display("FAIL hop_end: got up=%b hop=%b want 0 0", up, hop_active); end
    repeat (3) begin repeat (7) cycle(); tick_n(1); end
    key_down = 1'b1;
    cycle();
    key_down = 1'b0;
    checks++; if (hop_active !== 1'b0) begin errors++; $display("FAIL cooldown_ignores_key: got hop=%b want 0", hop_active); end
    repeat (7) cycle();
    tick_n(1);
    checks++; if (hop_active !== 1'b0) begin errors++; $display("FAIL cooldown_exit: got hop=%b want 0", hop_active); end
    key_down = 1'b1;
    cycle();
    key_down = 1'b0;
    checks++; if ({down, hop_active} !== 2'b11) begin errors++; $display("FAIL idle_after_cd: got down=%b hop=%b want 1 1", down, hop_active); end
    do_restart();
  endtask

  task automatic test_priority_repeat();
    left_seen = 1'b0;
    key_up = 1'b1;
    key_left = 1'b1;
    cycle();
    checks++; if ({up, left} !== 2'b10) begin errors++; $display("FAIL prio_first: got up=%b left=%b want 1 0", up, left); end
    for (int h = 0; h < 2; h++) begin
      tick_n(10);
      checks++; if (hop_active !== 1'b0) begin errors++; $display("FAIL repeat_cd%0d: got hop=%b want 0", h, hop_active); end
      tick_n(4);
      checks++; if (hop_active !== 1'b0) begin errors++; $display("FAIL repeat_idle%0d: got hop=%b want 0", h, hop_active); end
      cycle();
      checks++; if ({up, hop_active} !== 2'b11) begin errors++; $display("FAIL repeat_hop%0d: got up=%b hop=%b want 1 1", h, up, hop_active); end
    end
    key_up = 1'b0;
    key_left = 1'b0;
    checks++; if (left_seen !== 1'b0) begin errors++; $display("FAIL left_never: got %b want 0", left_seen); end
    do_restart();
  endtask

  task automatic test_collision();
    key_right = 1'b1;
    cycle();
    key_right = 1'b0;
    tick_n(4);
    checks++; if (right !== 1'b1) begin errors++; $display("FAIL coll_pre: got right=%b want 1", right); end
    collision = 1'b1;
    timer_done = 1'b1;
    cycle();
    collision = 1'b0;
    timer_done = 1'b0;
    checks++; if ({right, hop_active, reset_position} !== 3'b000) begin errors++; $display("FAIL coll_abort: got %b want 000", {right, hop_active, reset_position}); end
    tick_n(29);
    checks++; if (reset_position !== 1'b0) begin errors++; $display("FAIL dying_29: got rp=%b want 0", reset_position); end
    tick_n(1);
    checks++; if ({reset_position, lives} !== {1'b1, 3'd2}) begin errors++; $display("FAIL respawn: got rp=%b lives=%0d want 1 2", reset_position, lives); end
    cycle();
    checks++; if ({reset_position, lives, game_over} !== {1'b0, 3'd2, 1'b0}) begin errors++; $display("FAIL post_respawn: got rp=%b lives=%0d go=%b want 0 2 0", reset_position, lives, game_over); end
  endtask

  task automatic test_game_over();
    for (int d = 0; d < 2; d++) begin
      collision = 1'b1;
      cycle();
      collision = 1'b0;
      tick_n(30);
      checks++; if ({reset_position, lives} !== {1'b1, 3'(1 - d)}) begin errors++; $display("FAIL death%0d: got rp=%b lives=%0d want 1 %0d", d, reset_position, lives, 1 - d); end
      cycle();
    end
    checks++; if ({game_over, reset_position} !== 2'b10) begin errors++; $display("FAIL game_over: got go=%b rp=%b want 1 0", game_over, reset_position); end
    key_up = 1'b1;
    repeat (3) cycle();
    key_up = 1'b0;
    checks++; if ({up, hop_active, game_over} !== 3'b001) begin errors++; $display("FAIL go_keys: got %b want 001", {up, hop_active, game_over}); end
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    checks++; if ({reset_position, lives, score, game_over} !== {1'b1, 3'd3, 8'd0, 1'b0}) begin errors++; $display("FAIL restart: got rp=%b lives=%0d score=%0d go=%b want 1 3 0 0", reset_position, lives, score, game_over); end
    cycle();
    key_left = 1'b1;
    cycle();
    key_left = 1'b0;
    checks++; if ({left, hop_active, reset_position} !== 3'b110) begin errors++; $display("FAIL restart_idle: got %b want 110", {left, hop_active, reset_position}); end
    do_restart();
  endtask

  task automatic test_goal_saturate();
    for (int g = 0; g < 254; g++) begin
      reached_goal = 1'b1;
      cycle();
      reached_goal = 1'b0;
      cycle();
    end
    checks++; if ({score, lives} !== {8'd254, 3'd3}) begin errors++; $display("FAIL goal_254: got score=%0d lives=%0d want 254 3", score, lives); end
    key_up = 1'b1;
    cycle();
    key_up = 1'b0;
    tick_n(10);
    reached_goal = 1'b1;
    cycle();
    reached_goal = 1'b0;
    checks++; if ({score, reset_position, lives} !== {8'd255, 1'b1, 3'd3}) begin errors++; $display("FAIL goal_255: got score=%0d rp=%b lives=%0d want 255 1 3", score, reset_position, lives); end
    cycle();
    checks++; if (reset_position !== 1'b0) begin errors++; $display("FAIL goal_pulse1: got rp=%b want 0", reset_position); end
    key_up = 1'b1;
    cycle();
    key_up = 1'b0;
    tick_n(3);
    reached_goal = 1'b1;
    tick_n(1);
    reached_goal = 1'b0;
    checks++; if ({hop_active, reset_position, score} !== {1'b1, 1'b0, 8'd255}) begin errors++; $display("FAIL goal_in_hop: got hop=%b rp=%b score=%0d want 1 0 255", hop_active, reset_position, score); end
    tick_n(6);
    reached_goal = 1'b1;
    cycle();
    reached_goal = 1'b0;
    checks++; if ({score, reset_position, lives} !== {8'd255, 1'b1, 3'd3}) begin errors++; $display("FAIL goal_sat: got score=%0d rp=%b lives=%0d want 255 1 3", score, reset_position, lives); end
    cycle();
    checks++; if (reset_position !== 1'b0) begin errors++; $display("FAIL goal_pulse2: got rp=%b want 0", reset_position); end
  endtask

  task automatic test_coll_goal();
    collision = 1'b1;
    reached_goal = 1'b1;
    cycle();
    collision = 1'b0;
    reached_goal = 1'b0;
    checks++; if ({reset_position, score} !== {1'b0, 8'd255}) begin errors++; $display("FAIL cg_dying: got rp=%b score=%0d want 0 255", reset_position, score); end
    tick_n(29);
    checks++; if (reset_position !== 1'b0) begin errors++; $display("FAIL cg_29: got rp=%b want 0", reset_position); end
    tick_n(1);
    checks++; if ({reset_position, lives, score} !== {1'b1, 3'd2, 8'd255}) begin errors++; $display("FAIL cg_respawn: got rp=%b lives=%0d score=%0d want 1 2 255", reset_position, lives, score); end
    cycle();
  endtask

  task automatic test_reset_mid_hop();
    key_down = 1'b1;
    cycle();
    key_down = 1'b0;
    tick_n(3);
    checks++; if (down !== 1'b1) begin errors++; $display("FAIL mid_pre: got down=%b want 1", down); end
    #3 RESETn = 1'b0;
    #1;
    checks++; if ({up, down, left, right, hop_active, reset_position, game_over} !== 7'd0) begin errors++; $display("FAIL mid_outs: got %b want 0000000", {up, down, left, right, hop_active, reset_position, game_over}); end
    checks++; if ({lives, score} !== {3'd3, 8'd0}) begin errors++; $display("FAIL mid_regs: got lives=%0d score=%0d want 3 0", lives, score); end
    cycle();
    RESETn = 1'b1;
    cycle();
    key_up = 1'b1;
    cycle();
    key_up = 1'b0;
    checks++; if ({up, hop_active} !== 2'b11) begin errors++; $display("FAIL mid_idle: got up=%b hop=%b want 1 1", up, hop_active); end
  endtask

  initial begin
    RESETn = 1'b0; timer_done = 1'b0; restart = 1'b0;
    key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;
    collision = 1'b0; reached_goal = 1'b0; left_seen = 1'b0;
    test_reset();
    test_single_hop();
    test_priority_repeat();
    test_collision();
    test_game_over();
    test_goal_saturate();
    test_coll_goal();
    test_reset_mid_hop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
